// File: rtl/uart_pkg.sv
// Shared types and constants for the pixel packet UART transmitter.
// Holds the serializer state enum, packet geometry and the checksum helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int PKT_BYTES        = 5;
    localparam int BITS_PER_FRAME   = 10;
    localparam int DEF_CLKS_PER_BIT = 5208;

    function automatic logic [7:0] pkt_sum(
        input logic [7:0]  hdr,
        input logic [23:0] px
    );
        return hdr + px[23:16] + px[15:8] + px[7:0];
    endfunction

endpackage

// File: rtl/uart_pkt_tx_if.sv
// Packet handshake bundle: header plus RGB pixel, qualified by Strb/Ready.
interface uart_pkt_tx_if;

    logic        Strb;
    logic [7:0]  Header;
    logic [23:0] ImageData;
    logic        Ready;

    modport master (
        output Strb,
        output Header,
        output ImageData,
        input  Ready
    );

    modport slave (
        input  Strb,
        input  Header,
        input  ImageData,
        output Ready
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer, LSB first, registered tx line.
// A load is taken while idle or on the last cycle of a stop bit (ack).
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ack
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             take;

    assign bit_end = (cnt == CNT_MAX);
    assign ack     = (state == STOP) && bit_end;
    // Reloading on ack keeps consecutive frames gap-free.
    assign take    = load && ((state == IDLE) || ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (take) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= data;
            tx      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    tx  <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_pkt_tx.sv
// Pixel packet transmitter: Header, R, G, B, CheckSum over one 8N1 line.
// Sequences bytes into uart_tx_byte and owns the checksum and handshake.
module uart_pkt_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_pkt_tx_if.slave       pkt,
    output logic               tx,
    output logic               Busy,
    output logic               Done,
    output logic [7:0]         CheckSum
);

    localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

    logic        ready_q;
    logic [2:0]  byte_idx;
    logic [31:0] rest;
    logic        accept;
    logic        byte_ack;
    logic        next_load;
    logic        load;
    logic [7:0]  load_data;
    logic [7:0]  sum;

    assign sum       = pkt_sum(pkt.Header, pkt.ImageData);
    assign accept    = pkt.Strb && ready_q;
    assign next_load = !ready_q && byte_ack && (byte_idx != LAST_IDX);
    assign load      = accept || next_load;
    // Header goes straight from the bus; later bytes come from the buffer.
    assign load_data = accept ? pkt.Header : rest[31:24];

    assign pkt.Ready = ready_q;
    assign Busy      = !ready_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .data (load_data),
        .tx   (tx),
        .ack  (byte_ack)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b1;
            Done     <= 1'b0;
            CheckSum <= '0;
            byte_idx <= '0;
            rest     <= '0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                rest     <= {pkt.ImageData, sum};
                CheckSum <= sum;
                byte_idx <= '0;
                ready_q  <= 1'b0;
            end else if (!ready_q && byte_ack) begin
                if (byte_idx == LAST_IDX) begin
                    ready_q <= 1'b1;
                    Done    <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                    rest     <= rest << 8;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Scoreboard bench for uart_pkt_tx: stimulus queues expected bytes,
// a line monitor decodes 8N1 frames and checks them against the queue.
module tb_uart_pkt_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx;
    logic       Busy;
    logic       Done;
    logic [7:0] CheckSum;

    uart_pkt_tx_if bus ();

    uart_pkt_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pkt     (bus.slave),
        .tx      (tx),
        .Busy    (Busy),
        .Done    (Done),
        .CheckSum(CheckSum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    logic smp[FRAME];

    task automatic check_frame();
        logic [7:0] d;
        logic       shape;
        shape = 1'b1;
        for (int b = 0; b < 10; b++)
            for (int k = 1; k < CPB; k++)
                if (smp[b*CPB+k] !== smp[b*CPB]) shape = 1'b0;
        if (smp[0] !== 1'b0 || smp[FRAME-CPB] !== 1'b1) shape = 1'b0;
        for (int b = 0; b < 8; b++) d[b] = smp[(b+1)*CPB];
        chk("frame_shape", {31'd0, shape}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", d);
        end else begin
            chk("byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
    endtask

    // Line monitor: one sample per cycle, frame starts on the first low sample.
    initial begin
        logic mon_act;
        int   mon_n;
        mon_act = 1'b0;
        mon_n   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_act = 1'b0;
            end else if (mon_act || tx === 1'b0) begin
                if (!mon_act) begin
                    mon_act = 1'b1;
                    mon_n   = 0;
                end
                smp[mon_n] = tx;
                mon_n++;
                if (mon_n == FRAME) begin
                    mon_act = 1'b0;
                    check_frame();
                end
            end
        end
    end

    task automatic push_pkt(input logic [7:0] h, input logic [23:0] d,
                            input logic [7:0] cs);
        exp_q.push_back(h);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(cs);
    endtask

    task automatic send(input logic [7:0] h, input logic [23:0] d,
                        input logic [7:0] cs, output int t0);
        bus.Strb      = 1'b1;
        bus.Header    = h;
        bus.ImageData = d;
        push_pkt(h, d, cs);
        @(negedge clk);
        t0       = cyc;
        bus.Strb = 1'b0;
        chk("start_tx", {31'd0, tx}, 32'd0);
        chk("start_busy", {31'd0, Busy}, 32'd1);
        chk("start_ready", {31'd0, bus.Ready}, 32'd0);
        chk("start_checksum", {24'd0, CheckSum}, {24'd0, cs});
    endtask

    task automatic wait_done(input int t0, input string name);
        int n;
        n = 0;
        while (Done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (Done !== 1'b1) chk({name, "_done_timeout"}, 32'd0, 32'd1);
        else chk({name, "_done_latency"}, cyc - t0, 32'd200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.Strb      = 1'b0;
        bus.Header    = '0;
        bus.ImageData = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, bus.Ready}, 32'd1);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_checksum", {24'd0, CheckSum}, 32'd0);

        send(8'hA5, 24'h123456, 8'h41, t0);
        wait_done(t0, "single");
        chk("single_checksum", {24'd0, CheckSum}, 32'h41);
        chk("single_ready", {31'd0, bus.Ready}, 32'd1);
        @(negedge clk);
        chk("single_done_once", {31'd0, Done}, 32'd0);
        repeat (3) @(negedge clk);

        send(8'hFF, 24'hFFFFFF, 8'hFC, t0);
        repeat (20) @(negedge clk);
        bus.Header    = 8'h00;
        bus.ImageData = 24'h000000;
        bus.Strb      = 1'b1;
        push_pkt(8'h00, 24'h000000, 8'h00);
        wait_done(t0, "wrap");
        chk("b2b_done_cycle_tx", {31'd0, tx}, 32'd1);
        chk("b2b_done_cycle_busy", {31'd0, Busy}, 32'd0);
        chk("wrap_checksum_held", {24'd0, CheckSum}, 32'hFC);
        @(negedge clk);
        t0       = cyc;
        bus.Strb = 1'b0;
        chk("b2b_start_tx", {31'd0, tx}, 32'd0);
        chk("b2b_busy", {31'd0, Busy}, 32'd1);
        chk("b2b_checksum", {24'd0, CheckSum}, 32'h00);
        wait_done(t0, "b2b");
        repeat (3) @(negedge clk);

        send(8'h77, 24'hABCDEF, 8'hDE, t0);
        repeat (88) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ready", {31'd0, bus.Ready}, 32'd1);
        chk("postrst_done", {31'd0, Done}, 32'd0);
        chk("postrst_checksum", {24'd0, CheckSum}, 32'd0);
        chk("postrst_tx", {31'd0, tx}, 32'd1);

        send(8'h3C, 24'h010203, 8'h42, t0);
        wait_done(t0, "after_rst");
        chk("after_rst_checksum", {24'd0, CheckSum}, 32'h42);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_pkt_tx.md
# uart_pkt_tx

Serial transmitter for the image-pixel packet link. It accepts one header byte and one 24-bit RGB pixel through a valid/ready handshake, computes an 8-bit checksum, and shifts the 5-byte packet out on a single UART line (8N1, LSB first). It sits on the FPGA side of the link as the transmit end of the packet format (Header, ImageData, CheckSum) consumed by the `uart_rx` packet receiver.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); legal range ≥ 2.
- `clk` input 1: single clock; all logic rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Strb` input 1: packet valid; `Header`/`ImageData` are meaningful while high.
- `Header` input 8: packet header byte.
- `ImageData` input 24: pixel, R = [23:16], G = [15:8], B = [7:0].
- `Ready` output 1: high when a new packet can be accepted.
- `tx` output 1: UART serial line, idle high.
- `Busy` output 1: high while a packet is being shifted out.
- `Done` output 1: one-cycle pulse after the last stop bit of a packet.
- `CheckSum` output 8: checksum of the packet currently or most recently sent.

## Operation
- Reset values: `tx` = 1, `Ready` = 1, `Busy` = 0, `Done` = 0, `CheckSum` = 0.
- Accept: a packet is accepted on a rising edge where `Strb` && `Ready`.
  - On accept, `Header` and `ImageData` are latched into an internal 5-byte buffer.
  - `CheckSum` = (Header + R + G + B) mod 256, registered in the same edge.
- Byte order on the wire: Header, R, G, B, CheckSum.
- Each byte is 10 bits: start 0, d0..d7 (LSB first), stop 1. There is no idle gap between bytes or packets beyond the stop bit.
- State machine:
  - IDLE, START, DATA, STOP.
  - IDLE→START on accept.
  - START→DATA after `CLKS_PER_BIT` cycles.
  - DATA→STOP after 8 bit periods.
  - STOP→START (next byte) when byte index < 4.
  - STOP→IDLE when byte index = 4.
- Counters:
  - Bit-period counter 0..`CLKS_PER_BIT`-1, wraps to 0 at each bit boundary; width $clog2(`CLKS_PER_BIT`).
  - Bit index 0..7 and byte index 0..4, both reset to 0 on accept.
- `Strb` while `Ready` = 0 is ignored; inputs may change freely during transmission without affecting the packet.
- `Busy` = !`Ready`. `Busy` is high from the cycle after accept until the cycle `Done` pulses.
- Reset mid-packet: the packet is abandoned and `tx` returns to 1 asynchronously. All outputs take their reset values, and no partial byte is resumed after release.

## Timing
- `tx` falls (start bit of the Header byte) in the cycle after the accepting edge.
- Each bit is held exactly `CLKS_PER_BIT` cycles.
- A packet occupies 50 × `CLKS_PER_BIT` cycles from the first `tx` fall to the end of the last stop bit.
- `Done` pulses for 1 cycle in the first cycle after the final stop period. `Ready` returns to 1 in that same cycle.
- Back-to-back packets: if `Strb` is high in the `Done` cycle, the packet is accepted there. Its start bit follows directly, so the line never idles more than the stop bit.
- `CheckSum` is valid from the cycle after accept and holds until the next accept.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE/START/DATA/STOP);
  - `PKT_BYTES` = 5, `BITS_PER_FRAME` = 10;
  - default `CLKS_PER_BIT`.
- One natural sub-module: `uart_tx_byte`. It is a single-byte 8N1 serializer with a load/ack handshake and owns the bit-period and bit counters. `uart_pkt_tx` sequences the bytes and computes the checksum.

## Test plan
(All scenarios use `CLKS_PER_BIT` = 4.)
- Reset state: hold `rst_n` = 0, then release → `tx` = 1, `Ready` = 1, `Busy` = 0, `Done` = 0, `CheckSum` = 0.
- Single packet: `Header` = 0xA5, `ImageData` = 0x123456, `Strb` for 1 cycle.
  - `tx` bytes decode as A5, 12, 34, 56, 41.
  - `CheckSum` = 0x41.
  - `Done` pulses once, exactly 200 cycles after the first `tx` fall.
- Checksum wrap: `Header` = 0xFF, `ImageData` = 0xFFFFFF → last byte 0xFC, every bit exactly 4 cycles wide.
- Busy ignore and back-to-back:
  - Change inputs to 0x00/0x000000 with `Strb` held high mid-packet → the first packet is unchanged.
  - Second packet starts the cycle after `Done`, with no extra idle beyond the stop bit.
- Reset mid-packet: assert `rst_n` = 0 during the G byte → `tx` = 1 immediately.
  - After release, `Ready` = 1.
  - A new packet 0x3C/0x010203 sends 3C, 01, 02, 03, 42 cleanly.
